// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end that turns byte/half/word requests into whole-word RAM cycles.
// Optional MEM_ACC_BOUND_CHECK_EN makes word indices >= RAM_DEPTH an error instead of wrapping.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 4096
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;
  localparam logic [ADDR_WIDTH-1:0] MASK = ADDR_WIDTH'(RAM_DEPTH - 1);
  state_t state, state_nx;
  logic legal, misal, oor, req_err, accept;
  logic [ADDR_WIDTH-1:0] word_addr, addr_q;
  logic we_q;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic [4:0] sh_amt;
  logic [DATA_WIDTH-1:0] wr_data, bmask, merged, shifted, load_ext;
  assign legal = req_funct3_i[1:0] != 2'b11 && (req_we_i ? !req_funct3_i[2] : req_funct3_i != 3'b110);
  assign misal = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) || (req_funct3_i[1:0] == 2'b10 && |req_addr_i[1:0]);
`ifdef MEM_ACC_BOUND_CHECK_EN
  assign oor = req_addr_i[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(RAM_DEPTH);
`else
  assign oor = 1'b0;
`endif
  assign req_err   = !legal || misal || oor;
  assign word_addr = {2'b0, req_addr_i[ADDR_WIDTH-1:2]} & MASK;
  assign accept    = req_valid_i && state == IDLE;
  // Half accesses are aligned, so lane*8 is also the correct half shift.
  assign sh_amt   = {lane_q, 3'b0};
  assign bmask    = f3_q[0] ? 32'h0000ffff << sh_amt : 32'h000000ff << sh_amt;
  assign merged   = (ram_rd_data_i & ~bmask) | ((f3_q[0] ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}}) & bmask);
  assign shifted  = ram_rd_data_i >> sh_amt;
  assign load_ext = f3_q[1] ? ram_rd_data_i :
                    f3_q[0] ? {{16{shifted[15] & ~f3_q[2]}}, shifted[15:0]} :
                              {{24{shifted[7] & ~f3_q[2]}}, shifted[7:0]};
  assign req_ready_o   = state == IDLE && rst_n_i;
  assign rsp_valid_o   = state == RESP;
  assign ram_rd_en_o   = state == RD;
  assign ram_wr_en_o   = state == WR;
  assign ram_rd_addr_o = addr_q;
  assign ram_wr_addr_o = addr_q;
  assign ram_wr_data_o = wr_data;
  always_ff @(posedge sys_clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_valid_i) state_nx = req_err ? RESP : (req_we_i && req_funct3_i[1]) ? WR : RD;
      RD:   state_nx = WAIT;
      WAIT: state_nx = we_q ? WR : RESP;
      WR:   state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
      addr_q      <= '0;
      wr_data     <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        lane_q  <= req_addr_i[1:0];
        addr_q  <= word_addr;
        wr_data <= req_wdata_i;
        if (req_err) begin
          rsp_rdata_o <= '0;
          rsp_err_o   <= 1'b1;
        end
      end
      if (state == WAIT && we_q) wr_data <= merged;
      if (state == WAIT && !we_q) begin
        rsp_rdata_o <= load_ext;
        rsp_err_o   <= 1'b0;
      end
      if (state == WR) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
      end
    end
endmodule
